alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (32-bit, 4-bit control code, Zero flag) between two requesters.
//  Round-robin arbitration, operand/opcode registration, per-op execution timing (mul/div held
//  MULDIV_LAT cycles) and a registered response with valid/ready handshake.
//  Sits between the issue logic and the ALU; the ALU is instantiated outside this block.
// PARAMETERS
//  DATA_W      32  operand/result width
//  MULDIV_LAT  4   cycles ALU inputs are held before capture for mul(1111)/div(1110); legal range 1..15
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  req0_valid    in   1       requester 0 has an operation
//  req0_ready    out  1       requester 0 accepted this cycle
//  req0_a/req0_b in   DATA_W  operands (to Data_1/Data_2)
//  req0_op       in   4       ALU control code
//  req1_*        --   --      identical set for requester 1
//  alu_data_1    out  DATA_W  to ALU Data_1
//  alu_data_2    out  DATA_W  to ALU Data_2
//  alu_ctrl      out  4       to ALU_control_signal
//  alu_result    in   DATA_W  from ALU
//  alu_zero      in   1       from ALU Zero
//  rsp_valid     out  1       response available
//  rsp_ready     in   1       consumer takes response
//  rsp_id        out  1       requester that owns the response
//  rsp_result    out  DATA_W  captured ALU result (0 on error)
//  rsp_zero      out  1       captured Zero flag (0 on error)
//  rsp_err       out  1       opcode was not legal
// BEHAVIOUR
//  - Legal opcodes: 0010 add, 0110 sub, 1111 mul, 1110 div, 0000 and, 0001 or, 1100 nor, 0111 slt.
//  - Reset: state IDLE, alu_data_1/2=0, alu_ctrl=0000, rsp_valid/id/result/zero/err=0, last_grant=1
//    (req0 wins the first tie), counter=0. Reset mid-operation abandons it; no response issued.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: grant = only valid requester; both valid -> requester != last_grant.
//    reqN_ready = (state==IDLE) && grant==N, combinational; never both high; 0 outside IDLE.
//    On accept edge: latch a/b/op into alu_data_1/2, alu_ctrl; latch rsp_id=grant.
//    Legal op -> EXEC, counter = (op is 1111/1110) ? MULDIV_LAT-1 : 0.
//    Illegal op -> RESP directly: rsp_err=1, rsp_result=0, rsp_zero=0; alu_ctrl still updated.
//  - EXEC: ALU inputs stable. counter==0 -> capture alu_result/alu_zero into rsp_result/rsp_zero,
//    rsp_err=0, go RESP; else counter decrements.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then IDLE, last_grant=rsp_id.
//    Response is held indefinitely under backpressure; no new accept while in RESP.
//  - Latency (accept edge = T): single-cycle op rsp_valid high from T+2; mul/div from T+1+MULDIV_LAT;
//    illegal from T+1. Peak throughput: one op per 3 cycles (rsp_ready tied high).
//  - alu_* outputs hold last issued values in IDLE/RESP (no toggling when idle).
//  - Block does not interpret results: div-by-zero/overflow values pass through as given by the ALU.
//  - Requester deasserting valid before ready is allowed; nothing is latched for it.
// TESTING
//  1 Reset: rst_n=0 mid-EXEC of a mul -> next cycle all outputs 0, state IDLE, no rsp_valid after release.
//  2 req0 a=3 b=5 op=0010, rsp_ready=1 -> ready0 at T, rsp_valid at T+2, result=8, zero=0, id=0.
//  3 req1 a=3 b=5 op=1111, MULDIV_LAT=4 -> alu_ctrl=1111 held 4 cycles, rsp at T+5, result=15, id=1.
//  4 Both valid continuously (req0 a=5 b=5 op=0110, req1 op=0111 a=3 b=5) -> grants alternate 0,1,0,1;
//    req0 responses result=0 zero=1; req1 responses result=1 zero=0.
//  5 req0 op=1010 -> rsp_valid at T+1, rsp_err=1, result=0, zero=0; next op 0001 a=3 b=5 -> result=7, err=0.
//  6 rsp_ready=0 for 10 cycles after rsp_valid on and(a=3,b=5) -> rsp_result=1 stable, both readys 0,
//    accept resumes the cycle after rsp_ready=1.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester channels, the ALU operand/result pins and the
// response channel of alu_share_arbiter.
//   slave  : the arbiter's view (requests/ALU result/rsp_ready in, the rest out)
//   master : the surrounding issue logic / ALU / consumer view
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned OP_W = 4;

  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  // Shared ALU
  logic [DATA_W-1:0] alu_data_1;
  logic [DATA_W-1:0] alu_data_2;
  logic [OP_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // Response
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_data_1, alu_data_2, alu_ctrl,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_data_1, alu_data_2, alu_ctrl,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Round-robin grant in IDLE, operands/opcode registered onto the ALU pins,
// mul/div held MULDIV_LAT cycles before the result is captured, and the
// captured result is presented on a valid/ready response channel.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_share_arbiter_if.slave (requesters, ALU pins, response)
module alu_share_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_MUL = 4'b1111;
  localparam logic [OP_W-1:0] OP_DIV = 4'b1110;
  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_valid, grant;
  logic              ready0, ready1;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0]   sel_op;

  logic [DATA_W-1:0] data1_q, data2_q, rsp_result_q;
  logic [OP_W-1:0]   ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_err_q, last_grant_q;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_NOR, OP_SLT: op_legal = 1'b1;
      default:                       op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_muldiv(input logic [OP_W-1:0] op);
    op_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = op_legal(sel_op) ? EXEC : RESP;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant / ready / operand select; a tie goes to the requester not served last
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
    ready0 = grant_valid && !grant;
    ready1 = grant_valid && grant;
    sel_a  = grant ? bus.req1_a  : bus.req0_a;
    sel_b  = grant ? bus.req1_b  : bus.req0_b;
    sel_op = grant ? bus.req1_op : bus.req0_op;
  end

  // Datapath: ALU pins, execution counter, response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q      <= '0;
      data2_q      <= '0;
      ctrl_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            data1_q  <= sel_a;
            data2_q  <= sel_b;
            ctrl_q   <= sel_op;
            rsp_id_q <= grant;
            if (op_legal(sel_op)) begin
              cnt_q <= op_muldiv(sel_op) ? CNT_W'(MULDIV_LAT - 1) : '0;
            end else begin
              // Illegal opcode skips the ALU and reports straight away
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_valid_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            last_grant_q <= rsp_id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_data_1 = data1_q;
  assign bus.alu_data_2 = data2_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
